ps2_kbd_ctrl: RTL and testbench

Synthesizable PS/2 keyboard controller between the external PS/2 pins (driven in simulation by the keyboard model) and the core's keyboard MMIO device. It oversamples `ps2_clk`/`ps2_data` on the system clock and assembles 11-bit frames. It checks start, parity and stop bits, then runs a prefix state machine that folds `E0`/`F0` prefixes into single key events. Events are buffered in a FIFO and popped by the consumer with a valid/ready handshake.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_evt_fifo.sv | 61 ++++++
 rtl/ps2_kbd_ctrl.sv | 144 ++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard controller.
//   PS2_EXT / PS2_BRK   - extended and break prefix bytes
//   PS2_FRAME_BITS      - bits per PS/2 frame (start, 8 data, parity, stop)
//   ps2_state_e         - prefix FSM states
//   ps2_evt_t           - key event {ext, brk, code}
//   frame_ok()          - start/parity/stop check on an assembled frame
package ps2_pkg;

    localparam logic [7:0]  PS2_EXT        = 8'hE0;
    localparam logic [7:0]  PS2_BRK        = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int unsigned PS2_EVT_W = $bits(ps2_evt_t);

    // Frame is LSB first: [0] start, [8:1] data, [9] parity, [10] stop. Odd parity.
    function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
        return !f[0] && f[PS2_FRAME_BITS-1] && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous circular FIFO with extra-MSB pointers.
//   clk_i, rst_i - clock, asynchronous active-high reset
//   push_i       - write wdata_i; accepted when not full, or full with a pop in the same cycle
//   pop_i        - remove the head entry; ignored while empty
//   rdata_o      - head entry; holds the last popped entry while empty (zero after reset)
//   valid_o      - FIFO non-empty
//   drop_o       - one-cycle pulse when a push is refused because the FIFO is full
module ps2_evt_fifo #(
    parameter int unsigned Width = 10,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             valid_o,
    output logic             drop_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] last_q;
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             empty, full, do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty;
    // A pop frees the slot this cycle, so a simultaneous push into a full FIFO still fits.
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & full & ~do_pop;

    assign valid_o = ~empty;
    assign rdata_o = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard receiver with E0/F0 prefix folding and an event FIFO.
//   clk, rst              - system clock, asynchronous active-high reset
//   ps2_clk, ps2_data     - raw asynchronous PS/2 pins (idle high)
//   evt_valid / evt_ready - consumer handshake; pop on valid & ready
//   evt_code/ext/brk      - head event (code with prefixes stripped)
//   frame_err             - one-cycle pulse on a bad frame or a partial-frame timeout
//   overflow              - sticky; an event was dropped on a full FIFO
module ps2_kbd_ctrl #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       frame_err,
    output logic       overflow
);

    import ps2_pkg::*;

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]                clk_sync_q, dat_sync_q;
    logic                      neg;
    logic [PS2_FRAME_BITS-1:0] frame_q;
    logic [3:0]                bit_cnt_q;
    logic                      frame_done_q;
    logic [TO_W-1:0]           idle_cnt_q;
    logic                      timeout, frame_good, bad_frame;
    logic [7:0]                rx_byte;
    ps2_state_e                state_q;
    logic                      push, drop, overflow_q;
    ps2_evt_t                  push_evt, head;

    // Synchronizers; loaded with 1 so no false falling edge appears after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 3'b111;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[1:0], ps2_data};
        end
    end

    assign neg     = clk_sync_q[2] & ~clk_sync_q[1];
    assign timeout = (bit_cnt_q != 4'd0) && (idle_cnt_q == TO_W'(TIMEOUT_CYC));

    // Frame assembly; frame_done_q marks the cycle after the stop bit is shifted in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q      <= '0;
            bit_cnt_q    <= 4'd0;
            frame_done_q <= 1'b0;
            idle_cnt_q   <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (neg) begin
                frame_q    <= {dat_sync_q[2], frame_q[PS2_FRAME_BITS-1:1]};
                idle_cnt_q <= '0;
                if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
                    bit_cnt_q    <= 4'd0;
                    frame_done_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (timeout) begin
                bit_cnt_q  <= 4'd0;
                idle_cnt_q <= '0;
            end else if (bit_cnt_q != 4'd0) begin
                idle_cnt_q <= idle_cnt_q + TO_W'(1);
            end
        end
    end

    assign rx_byte    = frame_q[8:1];
    assign frame_good = frame_done_q & frame_ok(frame_q);
    assign bad_frame  = frame_done_q & ~frame_ok(frame_q);
    assign frame_err  = bad_frame | timeout;

    // Prefix FSM: E0/F0 accumulate into the state, any other byte consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (frame_err) begin
            state_q <= StIdle;
        end else if (frame_good) begin
            if (rx_byte == PS2_EXT) begin
                case (state_q)
                    StIdle:  state_q <= StExt;
                    StBrk:   state_q <= StExtBrk;
                    default: state_q <= state_q;
                endcase
            end else if (rx_byte == PS2_BRK) begin
                case (state_q)
                    StIdle:  state_q <= StBrk;
                    StExt:   state_q <= StExtBrk;
                    default: state_q <= state_q;
                endcase
            end else begin
                state_q <= StIdle;
            end
        end
    end

    assign push          = frame_good && (rx_byte != PS2_EXT) && (rx_byte != PS2_BRK);
    assign push_evt.ext  = (state_q == StExt) || (state_q == StExtBrk);
    assign push_evt.brk  = (state_q == StBrk) || (state_q == StExtBrk);
    assign push_evt.code = rx_byte;

    ps2_evt_fifo #(
        .Width (PS2_EVT_W),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (push_evt),
        .pop_i   (evt_ready),
        .rdata_o (head),
        .valid_o (evt_valid),
        .drop_o  (drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
    assign evt_code = head.code;
    assign evt_ext  = head.ext;
    assign evt_brk  = head.brk;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: table-driven bench for ps2_kbd_ctrl with a behavioural PS/2 keyboard.
// The PS/2 bit period is shortened to 20 clk cycles and the timeout to 200 cycles so the
// whole run stays short; both keep the 10x clock-ratio and timeout > bit-period relations.
module tb_ps2_kbd_ctrl;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned TB_TIMEOUT = 200;
    localparam int          HALF       = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext, evt_brk, frame_err, overflow;

    int errors = 0;
    int checks = 0;
    int err_cnt = 0;

    ps2_kbd_ctrl #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_brk   (evt_brk),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    typedef struct {
        logic [7:0] code;
        int         kind;      // 0 good, 1 parity inverted, 2 stop bit 0
        logic       exp_evt;
        logic [7:0] exp_code;
        logic       exp_ext;
        logic       exp_brk;
        int         exp_err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] c, input int k, input logic e, input logic [7:0] ec,
                       input logic x, input logic b, input int er);
        vec_t v;
        v.code = c; v.kind = k; v.exp_evt = e; v.exp_code = ec;
        v.exp_ext = x; v.exp_brk = b; v.exp_err = er;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int kind);
        logic [10:0] f;
        f = {(kind != 2), (~^b) ^ (kind == 1), b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        wait_clk(1);
        evt_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(evt_valid), 32'd0);
        check({tag, "_code"},  32'(evt_code),  32'd0);
        check({tag, "_ext"},   32'(evt_ext),   32'd0);
        check({tag, "_brk"},   32'(evt_brk),   32'd0);
        check({tag, "_ferr"},  32'(frame_err), 32'd0);
        check({tag, "_ovf"},   32'(overflow),  32'd0);
    endtask

    initial begin
        int          e0;
        logic [10:0] f;

        add(8'h1C, 0, 1, 8'h1C, 0, 0, 0);  // plain make
        add(8'hE0, 0, 0, 8'h00, 0, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 0, 0, 0);
        add(8'h75, 0, 1, 8'h75, 1, 1, 0);  // extended release
        add(8'hF0, 0, 0, 8'h00, 0, 0, 0);
        add(8'h1C, 0, 1, 8'h1C, 0, 1, 0);  // release
        add(8'hF0, 0, 0, 8'h00, 0, 0, 0);
        add(8'h1C, 1, 0, 8'h00, 0, 0, 1);  // bad parity drops pending F0
        add(8'h1C, 0, 1, 8'h1C, 0, 0, 0);
        add(8'hE0, 0, 0, 8'h00, 0, 0, 0);
        add(8'h12, 0, 1, 8'h12, 1, 0, 0);  // extended make
        add(8'hF0, 0, 0, 8'h00, 0, 0, 0);
        add(8'h33, 2, 0, 8'h00, 0, 0, 1);  // bad stop bit
        add(8'h33, 0, 1, 8'h33, 0, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 0, 0, 0);
        add(8'hE0, 0, 0, 8'h00, 0, 0, 0);
        add(8'h6B, 0, 1, 8'h6B, 1, 1, 0);  // F0 then E0 also folds to ext+brk
        add(8'hE0, 0, 0, 8'h00, 0, 0, 0);
        add(8'hE0, 0, 0, 8'h00, 0, 0, 0);
        add(8'h74, 0, 1, 8'h74, 1, 0, 0);  // repeated E0 stays extended

        wait_clk(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        wait_clk(5);

        foreach (vq[i]) begin
            e0 = err_cnt;
            send_frame(vq[i].code, vq[i].kind);
            check($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vq[i].exp_evt));
            check($sformatf("vec%0d_ferr_cnt", i), 32'(err_cnt - e0), 32'(vq[i].exp_err));
            if (vq[i].exp_evt) begin
                check($sformatf("vec%0d_code", i), 32'(evt_code), 32'(vq[i].exp_code));
                check($sformatf("vec%0d_ext", i),  32'(evt_ext),  32'(vq[i].exp_ext));
                check($sformatf("vec%0d_brk", i),  32'(evt_brk),  32'(vq[i].exp_brk));
                pop_one();
                check($sformatf("vec%0d_popped", i), 32'(evt_valid), 32'd0);
            end
        end

        // Overflow: nine makes into an eight-deep FIFO, then drain at one per cycle.
        for (int k = 1; k <= 9; k++) begin
            send_frame(8'(k), 0);
            if (k == 8) check("ovf_before_full_push", 32'(overflow), 32'd0);
        end
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head_valid", 32'(evt_valid), 32'd1);
        evt_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(evt_valid), 32'd1);
            check($sformatf("drain%0d_code", k), 32'(evt_code), 32'(k));
            wait_clk(1);
        end
        evt_ready = 1'b0;
        check("drain_empty", 32'(evt_valid), 32'd0);
        check("drain_hold_code", 32'(evt_code), 32'h08);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Timeout: five bits, then silence.
        e0 = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        wait_clk(TB_TIMEOUT - 30);
        check("timeout_not_yet", 32'(err_cnt - e0), 32'd0);
        wait_clk(60);
        check("timeout_err_once", 32'(err_cnt - e0), 32'd1);
        check("timeout_no_evt", 32'(evt_valid), 32'd0);
        send_frame(8'h2A, 0);
        check("after_to_valid", 32'(evt_valid), 32'd1);
        check("after_to_code", 32'(evt_code), 32'h2A);
        check("after_to_ext", 32'(evt_ext), 32'd0);
        check("after_to_brk", 32'(evt_brk), 32'd0);
        check("after_to_err_cnt", 32'(err_cnt - e0), 32'd1);
        pop_one();

        // Reset while the clock line is low for bit 6 of E0.
        f = {1'b1, 1'b0, 8'hE0, 1'b0};
        for (int i = 0; i < 6; i++) ps2_bit(f[i]);
        ps2_data = f[6];
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(2);
        rst = 1'b1;
        wait_clk(2);
        check_idle_outputs("midrst");
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(HALF);
        rst = 1'b0;
        wait_clk(HALF);
        e0 = err_cnt;
        send_frame(8'h1C, 0);
        check("midrst_valid", 32'(evt_valid), 32'd1);
        check("midrst_code", 32'(evt_code), 32'h1C);
        check("midrst_ext", 32'(evt_ext), 32'd0);
        check("midrst_brk", 32'(evt_brk), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt - e0), 32'd0);
        pop_one();
        check("midrst_single", 32'(evt_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
